// File: rtl/heater_pkg.sv
// Shared types and constants for the heater thermal controller.
package heater_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COOL  = 2'd1,
    ST_HEAT  = 2'd2,
    ST_FAULT = 2'd3
  } heat_state_e;

  localparam int ST_TEMP_LSB  = 0;
  localparam int ST_TEMP_W    = 12;
  localparam int ST_STATE_LSB = 12;
  localparam int ST_TMO_BIT   = 14;
  localparam int ST_TRIP_BIT  = 15;
  localparam int ST_ENT_LSB   = 16;
  localparam int ST_ENT_W     = 16;

  localparam logic [11:0] TRIP_CODE_DEF = 12'hA00;

endpackage

// File: rtl/heater_pwm.sv
// PWM gate for the heater: 256-cycle period, counter restarts on HEAT entry.
module heater_pwm
  import heater_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       in_heat,
  input  logic [7:0] cfg_duty,
  output logic       pwm_on
);

  logic [7:0] pwm_cnt_q;
  logic [7:0] pwm_cnt_d;

  // Held at zero outside HEAT, so every entry starts a fresh period.
  always_comb begin
    pwm_cnt_d = 8'd0;
    if (in_heat) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
    end
  end

  assign pwm_on = in_heat && (pwm_cnt_q < cfg_duty);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

endmodule

// File: rtl/heater_thermal_ctrl.sv
// Bang-bang heater controller with hysteresis, PWM gating and on-time timeout.
// Optional over-temperature trip enabled by HEATER_CTRL_TRIP_EN.
module heater_thermal_ctrl
  import heater_pkg::*;
#(
  parameter int                 BUS_WIDTH = 32,
  parameter int                 TEMP_W    = 12,
  parameter logic [TEMP_W-1:0]  TRIP_CODE = TEMP_W'(TRIP_CODE_DEF)
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  cfg_enable,
  input  logic [TEMP_W-1:0]     cfg_setpoint,
  input  logic [7:0]            cfg_hyst,
  input  logic [7:0]            cfg_duty,
  input  logic [31:0]           cfg_max_on,
  input  logic                  temp_valid,
  input  logic [TEMP_W-1:0]     temp_data,
  output logic [BUS_WIDTH-1:0]  heater_word,
  output logic [BUS_WIDTH-1:0]  status,
  output logic                  fault
);

  heat_state_e        state_q, state_d;
  logic [31:0]        on_cnt_q, on_cnt_d;
  logic [15:0]        ent_q, ent_d;
  logic               tmo_q, tmo_d;
  logic               trip_q, trip_d;
  logic [TEMP_W-1:0]  temp_q, temp_d;
  logic               heater_q, heater_d;
  logic               fault_q, fault_d;

  logic [TEMP_W:0]    hyst_x;
  logic [TEMP_W:0]    low;
  logic [32:0]        on_nxt;
  logic               below;
  logic               above;
  logic               tmo_hit;
  logic               trip_hit;
  logic               tmo_set;
  logic               trip_set;
  logic               pwm_on;
  logic [31:0]        st_w;

  assign hyst_x = (TEMP_W+1)'(cfg_hyst);
  assign low    = ({1'b0, cfg_setpoint} < hyst_x) ? '0
                : {1'b0, cfg_setpoint} - hyst_x;
  assign below  = temp_valid && ({1'b0, temp_data} < low);
  assign above  = temp_valid && (temp_data >= cfg_setpoint);

  // One extra bit so the +1 compare cannot alias on wrap.
  assign on_nxt  = {1'b0, on_cnt_q} + 33'd1;
  assign tmo_hit = (state_q == ST_HEAT) && (cfg_max_on != 32'd0)
                && (on_nxt == {1'b0, cfg_max_on});

`ifdef HEATER_CTRL_TRIP_EN
  assign trip_hit = temp_valid && (temp_data >= TRIP_CODE);
`else
  logic unused_trip;
  assign unused_trip = ^TRIP_CODE;
  assign trip_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tmo_set  = 1'b0;
    trip_set = 1'b0;
    if (!cfg_enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (temp_valid) begin
            state_d = below ? ST_HEAT : ST_COOL;
          end
        end
        ST_COOL: begin
          if (trip_hit) begin
            state_d  = ST_FAULT;
            trip_set = 1'b1;
          end else if (below) begin
            state_d = ST_HEAT;
          end
        end
        ST_HEAT: begin
          if (trip_hit || tmo_hit) begin
            state_d  = ST_FAULT;
            trip_set = trip_hit;
            tmo_set  = tmo_hit;
          end else if (above) begin
            state_d = ST_COOL;
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    on_cnt_d = 32'd0;
    ent_d    = ent_q;
    tmo_d    = tmo_q | tmo_set;
    trip_d   = trip_q | trip_set;
    temp_d   = temp_valid ? temp_data : temp_q;
    heater_d = pwm_on;
    fault_d  = (state_q == ST_FAULT);
    // Saturates only when no timeout is configured.
    if (state_q == ST_HEAT) begin
      on_cnt_d = on_nxt[32] ? on_cnt_q : on_nxt[31:0];
    end
    if ((state_d == ST_HEAT) && (state_q != ST_HEAT)
        && (ent_q != 16'hFFFF)) begin
      ent_d = ent_q + 16'd1;
    end
    if ((state_q == ST_FAULT) && (state_d == ST_IDLE)) begin
      tmo_d  = 1'b0;
      trip_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      on_cnt_q <= 32'd0;
      ent_q    <= 16'd0;
      tmo_q    <= 1'b0;
      trip_q   <= 1'b0;
      temp_q   <= '0;
      heater_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      on_cnt_q <= on_cnt_d;
      ent_q    <= ent_d;
      tmo_q    <= tmo_d;
      trip_q   <= trip_d;
      temp_q   <= temp_d;
      heater_q <= heater_d;
      fault_q  <= fault_d;
    end
  end

  heater_pwm u_pwm (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .in_heat  (state_q == ST_HEAT),
    .cfg_duty (cfg_duty),
    .pwm_on   (pwm_on)
  );

  always_comb begin
    st_w = 32'd0;
    st_w[ST_TEMP_LSB +: ST_TEMP_W] = ST_TEMP_W'(temp_q);
    st_w[ST_STATE_LSB +: 2]        = state_q;
    st_w[ST_TMO_BIT]               = tmo_q;
    st_w[ST_TRIP_BIT]              = trip_q;
    st_w[ST_ENT_LSB +: ST_ENT_W]   = ent_q;
  end

  assign heater_word = {{(BUS_WIDTH-1){1'b0}}, heater_q};
  assign status      = BUS_WIDTH'(st_w);
  assign fault       = fault_q;

endmodule
